sync_fifo_rd_stream: RTL
========================

// Module: sync_fifo_rd_stream
// PURPOSE
//  Read-side adapter directly downstream of the synchronous FIFO (sync_fifo_top).
//  Converts the FIFO rden/rddata/empty interface (1-cycle read latency) into a
//  valid/ready stream. A 2-entry prefetch buffer sustains 1 word/clk with m_ready
//  held high. Provides an in-order flush that discards all prefetched data.
// PARAMETERS
//  FIFO_WIDTH  8  data width; equals FIFO_WIDTH of the upstream FIFO
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           synchronous reset, active-high
//  fifo_empty   in   1           upstream FIFO empty flag
//  fifo_rddata  in   FIFO_WIDTH  upstream read data, valid the cycle after accepted rden
//  fifo_rden    out  1           read strobe to upstream FIFO
//  m_valid      out  1           stream word valid
//  m_data       out  FIFO_WIDTH  stream word (head of buffer)
//  m_ready      in   1           downstream ready
//  flush        in   1           discard buffered and in-flight words
//  buf_level    out  2           words currently held in buffer (0..2)
// BEHAVIOUR
//  Interface and reset
//  - One clock. Reset is synchronous and active-high.
//  - While rst=1: fifo_rden=0. On the edge with rst=1: m_valid=0, m_data=0,
//    buf_level=0, inflight=0.
//  - rst has priority over flush; flush has priority over normal operation.
//  State and read issue
//  - State is occ (0,1,2 = EMPTY/ONE/TWO) plus inflight (rden issued in the
//    previous cycle).
//  - pop = m_valid & m_ready.
//  - fifo_rden = !rst & !flush & !fifo_empty & ((occ + inflight - pop) < 2).
//    This is a combinational path from m_ready to fifo_rden and is intentional;
//    it is required for full throughput.
//  - Invariant: occ + inflight <= 2 at every edge. The buffer never overflows
//    and no read data is ever dropped.
//  - fifo_rden asserted while fifo_empty=1 never occurs.
//  - inflight_next = fifo_rden.
//  Buffer update (per edge)
//  - arrive = inflight & !flush; the arriving word is fifo_rddata.
//  - pop only:   head <= tail; occ-1.
//  - arrive only: the word is written to the first free slot; occ+1.
//  - pop & arrive, occ=1: head <= fifo_rddata; occ stays 1.
//  - pop & arrive, occ=2: head <= tail, tail <= fifo_rddata; occ stays 2.
//  - Ordering is strict FIFO. m_data holds the head; m_data is held stable while
//    m_valid=1 and m_ready=0.
//  - m_valid = (occ != 0); it is registered state. buf_level = occ.
//  Latency and throughput
//  - FIFO goes non-empty into an idle block: rden at cycle N, m_valid=1 at N+2.
//  - With m_ready=1 and the FIFO non-empty, one word transfers every clk.
//  Flush
//  - On an edge with flush=1: occ <= 0, inflight <= 0, m_valid <= 0.
//  - A word arriving on that edge is discarded.
//  - fifo_rden=0 during the flush cycle.
//  - A pop coincident with flush still counts as a completed transfer
//    downstream; the buffer is then cleared.
//  Boundary conditions
//  - fifo_empty rises while a read is in flight: the in-flight word is still
//    captured.
//  - m_ready low for a long time: occ saturates at 2, rden stays 0, and FIFO
//    data stays in the FIFO.
//  - Reset mid-stream: all buffered and in-flight words are lost. The upstream
//    FIFO is reset in the same cycle.
// TESTING
//  1 Reset: rst=1 for 2 clk with fifo_empty=0 -> fifo_rden=0, m_valid=0,
//    buf_level=0, m_data=0.
//  2 Streaming: FIFO holds 8'h01..8'h08, m_ready=1 -> m_data 01..08 on 8
//    consecutive cycles, first word 2 clk after first rden.
//  3 Backpressure: m_ready=0 with 5 words in FIFO -> buf_level=2, rden stops
//    after 2 reads. Release m_ready -> words appear in order, no loss or
//    duplication.
//  4 Simultaneous events: occ=2, pop and arrive on the same edge -> order
//    preserved (A,B,C stays A then B then C), buf_level stays 2.
//  5 Flush with inflight=1 and occ=1 -> next cycle m_valid=0, buf_level=0, the
//    in-flight word is never output, and the following FIFO word is output next.
//  6 Random m_ready/fifo_empty for 10k cycles vs scoreboard -> exact order
//    match, and never rden & fifo_empty, never occ+inflight>2.

Source files
------------

// File: rtl/sync_fifo_rd_stream_if.sv
// Read-side bundle between the synchronous FIFO, the stream adapter and the downstream consumer.
// The master modport is the adapter's view; the slave modport is the view of its surroundings.
interface sync_fifo_rd_stream_if #(
    parameter int FIFO_WIDTH = 8
);
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_rddata;
    logic                  fifo_rden;
    logic                  m_valid;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_ready;
    logic                  flush;
    logic [1:0]            buf_level;

    modport master (
        input  fifo_empty,
        input  fifo_rddata,
        input  m_ready,
        input  flush,
        output fifo_rden,
        output m_valid,
        output m_data,
        output buf_level
    );

    modport slave (
        output fifo_empty,
        output fifo_rddata,
        output m_ready,
        output flush,
        input  fifo_rden,
        input  m_valid,
        input  m_data,
        input  buf_level
    );
endinterface

// File: rtl/sync_fifo_rd_stream.sv
// Turns the FIFO's rden/rddata/empty port (1-cycle read latency) into a valid/ready stream.
// A 2-entry prefetch buffer (head/tail) sustains one word per clock and supports an in-order flush.
module sync_fifo_rd_stream #(
    parameter int FIFO_WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    sync_fifo_rd_stream_if.master bus
);
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                  r_occ;
    logic                  r_inflight;
    logic                  r_valid;
    logic [FIFO_WIDTH-1:0] r_head;
    logic [FIFO_WIDTH-1:0] r_tail;

    occ_t                  w_occ_next;
    logic [FIFO_WIDTH-1:0] w_head_next;
    logic [FIFO_WIDTH-1:0] w_tail_next;
    logic                  w_pop;
    logic                  w_arrive;
    logic                  w_rden;
    logic [2:0]            w_fill;

    assign w_pop    = r_valid & bus.m_ready;
    assign w_arrive = r_inflight & ~bus.flush;

    // Words committed after this edge; the m_ready term keeps the read path at full rate.
    assign w_fill = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rden = ~rst & ~bus.flush & ~bus.fifo_empty & (w_fill < 3'd2);

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        w_occ_next  = r_occ;
        w_head_next = r_head;
        w_tail_next = r_tail;
        case ({w_pop, w_arrive})
            2'b10: begin
                w_head_next = r_tail;
                w_occ_next  = (r_occ == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
            end
            2'b01: begin
                if (r_occ == OCC_EMPTY) begin
                    w_head_next = bus.fifo_rddata;
                    w_occ_next  = OCC_ONE;
                end else begin
                    w_tail_next = bus.fifo_rddata;
                    w_occ_next  = OCC_TWO;
                end
            end
            2'b11: begin
                if (r_occ == OCC_TWO) begin
                    w_head_next = r_tail;
                    w_tail_next = bus.fifo_rddata;
                end else begin
                    w_head_next = bus.fifo_rddata;
                end
            end
            default: begin
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= OCC_EMPTY;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            // NOTE: the two data slots are reset because m_data must read 0 out of reset.
            r_head     <= '0;
            r_tail     <= '0;
        end else if (bus.flush) begin
            r_occ      <= OCC_EMPTY;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= w_rden;
            r_valid    <= (w_occ_next != OCC_EMPTY);
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
        end
    end

    assign bus.fifo_rden = w_rden;
    assign bus.m_valid   = r_valid;
    assign bus.m_data    = r_head;
    assign bus.buf_level = r_occ;

    a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(w_rden && bus.fifo_empty));
    a_no_overcommit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, r_occ} + {2'b00, r_inflight}) <= 3'd2);
    a_valid_tracks_occ: assert property (@(posedge clk) disable iff (rst)
        r_valid == (r_occ != OCC_EMPTY));
endmodule
